// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: GPIO out/in, free-running timer with compare flag,
// and an 8N1 UART transmitter fed by a small TX FIFO.
module io_port_bank #(
    parameter int CLKS_PER_BIT   = 104,
    parameter int FIFO_DEPTH_LOG = 2,
    parameter int GPIO_OUT_W     = 8,
    parameter int GPIO_IN_W      = 8
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic [7:0]            io_addr,
    input  logic                  io_en,
    input  logic                  io_we,
    input  logic [31:0]           io_data_write,
    output logic [31:0]           io_data_read,
    output logic [GPIO_OUT_W-1:0] gpio_out,
    input  logic [GPIO_IN_W-1:0]  gpio_in,
    output logic                  uart_tx,
    output logic                  timer_irq
);

    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG;
    localparam int PTR_W  = FIFO_DEPTH_LOG;
    localparam int CNT_W  = FIFO_DEPTH_LOG + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [5:0] A_GPIO_OUT  = 6'd0;
    localparam logic [5:0] A_GPIO_IN   = 6'd1;
    localparam logic [5:0] A_TIMER     = 6'd2;
    localparam logic [5:0] A_TIMER_CMP = 6'd3;
    localparam logic [5:0] A_UART_TX   = 6'd4;
    localparam logic [5:0] A_UART_STAT = 6'd5;
    localparam logic [5:0] A_IRQ_STAT  = 6'd6;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [5:0]            word;
    logic                  wr_en, rd_en;
    logic                  unused_addr_bits;

    logic [GPIO_OUT_W-1:0] gpio_out_q;
    logic [GPIO_IN_W-1:0]  sync1_q, sync2_q;
    logic [31:0]           timer_q, timer_d;
    logic [31:0]           cmp_q;
    logic                  irq_q, irq_d;
    logic                  ovf_q, ovf_d;

    logic [7:0]            mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  fifo_full, fifo_empty, push_req, push, pop;

    uart_state_t           state_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [2:0]            bit_q;
    logic [7:0]            shift_q;
    logic                  tx_q;
    logic                  tx_idle;

    assign word             = io_addr[7:2];
    assign unused_addr_bits = ^io_addr[1:0];
    assign wr_en            = io_en && io_we;
    assign rd_en            = io_en && !io_we;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_req   = wr_en && (word == A_UART_TX);
    assign push       = push_req && !fifo_full;
    // The shifter takes a byte whenever it is idle or finishing a stop bit.
    assign pop        = !fifo_empty &&
                        ((state_q == S_IDLE) || (state_q == S_STOP && baud_q == BAUD_LAST));
    assign tx_idle    = fifo_empty && (state_q == S_IDLE);

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (wr_en && word == A_TIMER) timer_d = io_data_write;

        irq_d = irq_q;
        if (wr_en && word == A_IRQ_STAT && io_data_write[0]) irq_d = 1'b0;
        if (timer_q == cmp_q) irq_d = 1'b1;

        ovf_d = ovf_q;
        if (wr_en && word == A_IRQ_STAT && io_data_write[2]) ovf_d = 1'b0;
        if (push_req && fifo_full) ovf_d = 1'b1;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            timer_q    <= '0;
            cmp_q      <= 32'hFFFF_FFFF;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            timer_q <= timer_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (wr_en && word == A_GPIO_OUT)  gpio_out_q <= io_data_write[GPIO_OUT_W-1:0];
            if (wr_en && word == A_TIMER_CMP) cmp_q      <= io_data_write;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= io_data_write[7:0];
    end

    // UART shifter; tx_q is updated together with each state change.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (!fifo_empty) begin
                        shift_q <= mem_q[rd_ptr_q];
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (!fifo_empty) begin
                            shift_q <= mem_q[rd_ptr_q];
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        io_data_read = '0;
        if (rd_en) begin
            case (word)
                A_GPIO_OUT:  io_data_read = 32'(gpio_out_q);
                A_GPIO_IN:   io_data_read = 32'(sync2_q);
                A_TIMER:     io_data_read = timer_q;
                A_TIMER_CMP: io_data_read = cmp_q;
                A_UART_STAT: io_data_read = (32'(count_q) << 3) | {29'd0, ovf_q, tx_idle, fifo_full};
                A_IRQ_STAT:  io_data_read = {31'd0, irq_q};
                default:     io_data_read = '0;
            endcase
        end
    end

    assign gpio_out  = gpio_out_q;
    assign uart_tx   = tx_q;
    assign timer_irq = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: bus reads via an expected queue,
// UART frames decoded against a queue of pushed bytes.
module tb_io_port_bank;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        resetb;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in;
  logic        uart_tx;
  logic        timer_irq;

  logic [31:0] exp_q[$];
  logic [7:0]  uart_exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  io_port_bank #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH_LOG(2),
    .GPIO_OUT_W(8),
    .GPIO_IN_W(8)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .io_addr(io_addr),
    .io_en(io_en),
    .io_we(io_we),
    .io_data_write(io_data_write),
    .io_data_read(io_data_read),
    .gpio_out(gpio_out),
    .gpio_in(gpio_in),
    .uart_tx(uart_tx),
    .timer_irq(timer_irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: called just after a falling edge, return just after a falling edge
  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    io_en = 1'b1;
    io_we = 1'b1;
    io_addr = addr;
    io_data_write = data;
    @(negedge clk);
    io_en = 1'b0;
    io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    io_en = 1'b1;
    io_we = 1'b0;
    io_addr = addr;
    exp_q.push_back(exp);
    #2;
    e = exp_q.pop_front();
    check(tag, io_data_read, e);
    io_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic uart_push(input logic [7:0] b, input bit accepted);
    if (accepted) uart_exp_q.push_back(b);
    bus_write(8'h10, {24'hDEAD_BE, b});
  endtask

  // UART scoreboard: every cycle of a frame is compared with the expected level
  bit         mon_en = 1'b0;
  int         mon_cnt = -1;
  int         mon_cyc = 0;
  int         last_end_cyc = -100;
  int         frames_done = 0;
  int         contig = 0;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    int b;
    logic lvl;
    mon_cyc++;
    if (!mon_en || !resetb) begin
      mon_cnt = -1;
    end else if (mon_cnt < 0) begin
      if (uart_tx == 1'b0) begin
        if (uart_exp_q.size() == 0) begin
          check("uart_unexpected_frame", 32'd1, 32'd0);
          mon_byte = 8'h00;
        end else begin
          mon_byte = uart_exp_q[0];
        end
        if (last_end_cyc == mon_cyc - 1) contig++;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
    end
    if (mon_cnt >= 0) begin
      b = mon_cnt / CPB;
      if (b == 0)      lvl = 1'b0;
      else if (b <= 8) lvl = mon_byte[b-1];
      else             lvl = 1'b1;
      check("uart_bit", {31'd0, uart_tx}, {31'd0, lvl});
      if (mon_cnt == 10 * CPB - 1) begin
        if (uart_exp_q.size() != 0) void'(uart_exp_q.pop_front());
        frames_done++;
        last_end_cyc = mon_cyc;
        mon_cnt = -1;
      end
    end
  end

  initial begin
    int target;
    resetb = 1'b0;
    io_addr = 8'h00;
    io_en = 1'b0;
    io_we = 1'b0;
    io_data_write = 32'h0;
    gpio_in = 8'h00;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    mon_en = 1'b1;

    // reset state
    idle(10);
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_timer_irq", {31'd0, timer_irq}, 32'd0);
    check("reset_gpio_out", 32'(gpio_out), 32'd0);
    bus_read(8'h14, 32'h0000_0002, "reset_uart_stat");
    bus_read(8'h0C, 32'hFFFF_FFFF, "reset_cmp");
    bus_read(8'h18, 32'h0000_0000, "reset_irq_stat");

    // GPIO out, unmapped and write-only offsets
    bus_write(8'h00, 32'h0000_00A5);
    check("gpio_out_pin", 32'(gpio_out), 32'h0000_00A5);
    bus_read(8'h00, 32'h0000_00A5, "gpio_out_read");
    bus_write(8'h00, 32'hFFFF_FF5A);
    bus_read(8'h00, 32'h0000_005A, "gpio_out_upper_zero");
    bus_read(8'h1C, 32'h0, "unmapped_read");
    bus_read(8'h10, 32'h0, "uart_tx_reads_zero");
    io_addr = 8'h0C;
    #2;
    check("no_en_read_zero", io_data_read, 32'h0);
    @(negedge clk);

    // GPIO in synchroniser: visible from the 2nd cycle after the drive
    gpio_in = 8'h3C;
    bus_read(8'h04, 32'h0, "gpio_in_cycle0");
    bus_read(8'h04, 32'h0, "gpio_in_cycle1");
    bus_read(8'h04, 32'h0000_003C, "gpio_in_cycle2");

    // timer wrap and compare
    bus_write(8'h08, 32'hFFFF_FFFE);
    bus_write(8'h0C, 32'h0000_0001);
    bus_read(8'h08, 32'hFFFF_FFFF, "timer_max");
    bus_read(8'h08, 32'h0000_0000, "timer_wrap");
    check("irq_before_match", {31'd0, timer_irq}, 32'd0);
    bus_read(8'h18, 32'h0, "irq_stat_before_match");
    check("irq_after_match", {31'd0, timer_irq}, 32'd1);
    bus_read(8'h18, 32'h1, "irq_stat_after_match");
    bus_write(8'h18, 32'h1);
    check("irq_w1c", {31'd0, timer_irq}, 32'd0);
    // clear landing on the match edge: set wins
    bus_write(8'h0C, 32'h0000_0100);
    bus_write(8'h08, 32'h0000_00FE);
    idle(2);
    bus_write(8'h18, 32'h1);
    check("irq_set_beats_clear", {31'd0, timer_irq}, 32'd1);
    idle(3);
    check("irq_sticky", {31'd0, timer_irq}, 32'd1);
    bus_write(8'h18, 32'h1);
    check("irq_cleared", {31'd0, timer_irq}, 32'd0);

    // single frame and tx_idle timing
    uart_push(8'h55, 1'b1);
    bus_read(8'h14, 32'h0000_0008, "stat_queued");
    idle(10 * CPB - 1);
    bus_read(8'h14, 32'h0000_0000, "stat_in_stop");
    bus_read(8'h14, 32'h0000_0002, "stat_idle_after_stop");
    check("frames_after_single", frames_done, 32'd1);

    // overflow and back-to-back frames
    contig = 0;
    uart_push(8'h11, 1'b1);
    uart_push(8'h22, 1'b1);
    uart_push(8'h33, 1'b1);
    uart_push(8'h44, 1'b1);
    uart_push(8'hA7, 1'b1);
    uart_push(8'hEE, 1'b0);
    bus_read(8'h14, 32'h0000_0025, "stat_full_overflow");
    target = 6;
    for (int i = 0; i < 400 && frames_done < target; i++) @(negedge clk);
    check("frames_after_burst", frames_done, target);
    check("frames_contiguous", contig, 32'd4);
    idle(2);
    bus_read(8'h14, 32'h0000_0006, "stat_idle_ovf_sticky");
    bus_write(8'h18, 32'h4);
    bus_read(8'h14, 32'h0000_0002, "stat_ovf_cleared");

    // reset in the middle of a DATA phase
    uart_push(8'h0F, 1'b1);
    uart_push(8'hF0, 1'b1);
    uart_push(8'h81, 1'b1);
    uart_push(8'h18, 1'b1);
    uart_push(8'h99, 1'b1);
    uart_push(8'h66, 1'b0);
    idle(10);
    mon_en = 1'b0;
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    uart_exp_q.delete();
    check("midframe_reset_tx", {31'd0, uart_tx}, 32'd1);
    bus_read(8'h08, 32'h0, "midframe_reset_timer");
    bus_read(8'h14, 32'h0000_0002, "midframe_reset_stat");
    bus_read(8'h00, 32'h0, "midframe_reset_gpio");
    bus_read(8'h0C, 32'hFFFF_FFFF, "midframe_reset_cmp");
    check("midframe_reset_irq", {31'd0, timer_irq}, 32'd0);
    mon_en = 1'b1;

    // shifter still works after reset
    target = frames_done + 1;
    uart_push(8'hC3, 1'b1);
    for (int i = 0; i < 100 && frames_done < target; i++) @(negedge clk);
    check("frame_after_reset", frames_done, target);
    check("uart_queue_drained", uart_exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
